wash_timer: RTL
===============

# wash_timer

Wash-cycle countdown sequencer for the washing-machine controller. Steps through WASH, RINSE and (optionally) SPIN phases, each lasting a parameterised number of seconds, derived from the system clock by an internal prescaler. Drives the two-digit packed-BCD `seconds` bus consumed directly by the 7-segment scan/display stage, plus phase and status flags.

## Interface
- `TICK_DIV`, 50_000_000: CP cycles per one-second tick; must be ≥2.
- `WASH_SEC`, 30: WASH phase length in seconds, decimal, 1..99.
- `RINSE_SEC`, 20: RINSE phase length in seconds, decimal, 1..99.
- `SPIN_SEC`, 10: SPIN phase length in seconds, decimal, 1..99.
- `CP` in 1: system clock; all logic on posedge CP.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: begin a cycle; sampled only in IDLE.
- `pause` in 1: level; while high, the countdown and prescaler freeze.
- `seconds` out 8: remaining seconds of the current phase, packed BCD; [7:4] tens, [3:0] units.
- `phase` out 2: 0 IDLE, 1 WASH, 2 RINSE, 3 SPIN.
- `busy` out 1: high in any non-IDLE phase.
- `done` out 1: one-cycle pulse on cycle completion.

## Operation
- Reset values: `seconds`=8'h00, `phase`=0, `busy`=0, `done`=0, prescaler=0. RST dominates all other inputs, including mid-cycle; the cycle is aborted and no `done` pulse is issued.
- IDLE: `start`=1 loads `seconds` with BCD(WASH_SEC), sets `phase`=1 and `busy`=1, and clears the prescaler. `start` outside IDLE is ignored.
- Prescaler counts 0..TICK_DIV-1 only when `busy` && !`pause`. The tick is asserted on the cycle it equals TICK_DIV-1, and it then wraps to 0. Paused, it holds its value.
- On a tick:
  - If `seconds` > 01, decrement `seconds` in BCD. Units borrow: x0 becomes (x-1)9. The tens digit never underflows.
  - If `seconds` == 01, the phase ends:
    - WASH loads BCD(RINSE_SEC) and moves to phase 2.
    - RINSE moves to SPIN (see Configuration) or finishes.
    - SPIN finishes.
- Finish: `seconds`=00, `phase`=0, `busy`=0, `done`=1 for exactly that one cycle.
- Each phase therefore spans exactly N ticks. `seconds` never shows 00 while busy.
- BCD conversion of the parameters is done at elaboration (constant function). Out-of-range parameters are a compile-time error.

## Timing
- Start latency: `start` sampled high at edge k makes `seconds`/`phase`/`busy` valid after edge k.
- With no pause, the first decrement is visible after edge k+TICK_DIV. Each later tick follows TICK_DIV cycles after the previous one.
- `pause` acts on the same edge it is sampled. A tick that would fire while `pause`=1 is deferred, not lost. The total cycle length grows by exactly the number of paused cycles.
- `start` and `pause` high together in IDLE: the start is accepted, and counting begins the first cycle `pause` is low.
- `done` coincides with `seconds`=00 and `phase`=0. A new `start` is accepted on the cycle after `done`.

## Configuration
- `WASH_SPIN_EN` defined: the sequence is WASH→RINSE→SPIN→IDLE. SPIN loads BCD(SPIN_SEC).
- `WASH_SPIN_EN` undefined: the sequence is WASH→RINSE→IDLE. `phase` never equals 3, `SPIN_SEC` is unused, and no SPIN logic is synthesised.

## Structure
- Shared package `wash_pkg`:
  - phase encodings `PH_IDLE`, `PH_WASH`, `PH_RINSE`, `PH_SPIN`;
  - constant function `to_bcd8` (decimal 0..99 to packed BCD).
- Sub-module `wash_tick_gen`: the prescaler, with `CP`, `RST`, `clr`, `en` inputs and a one-cycle `tick` output. The FSM and BCD decrementer stay in `wash_timer`.

## Test plan
All scenarios use TICK_DIV=4, WASH_SEC=3, RINSE_SEC=2, SPIN_SEC=2 unless noted.
- Reset: assert RST for 2 cycles with `start`=1 → `seconds`=00, `phase`=0, `busy`=0, `done`=0 throughout.
- Start and decrement: `start` pulse at edge k → after k: `seconds`=03, `phase`=1. After k+4: 02. After k+8: 01. After k+12: `seconds`=02, `phase`=2.
- Full cycle:
  - With `WASH_SPIN_EN`: `phase`=3 after k+20, and `done`=1 for one cycle after k+28, with `seconds`=00 and `phase`=0.
  - Without the macro: `done` occurs after k+20, and `phase` never reaches 3.
- Pause: hold `pause`=1 for 10 cycles starting at k+6 → `seconds` stays 02 during the pause, and `done` moves to k+38 (macro defined).
- Ignored start and abort: `start` at k+5 has no effect. RST at k+14 → all outputs return to reset values next cycle, and no `done` pulse occurs. A fresh `start` then restarts at 03.
- BCD borrow: WASH_SEC=20 → 20→19 on the first tick; later 10→09; 01 then transitions to RINSE.

Source files
------------

// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared phase encodings and BCD helper for the wash timer
// Purpose: phase enum used by wash_timer and its bench, plus to_bcd8, the
//          elaboration-time decimal to packed-BCD converter.
// Ports:   none (package).
package wash_pkg;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_WASH  = 2'd1,
    PH_RINSE = 2'd2,
    PH_SPIN  = 2'd3
  } phase_t;

  // Decimal 0..99 to packed BCD: [7:4] tens, [3:0] units.
  function automatic logic [7:0] to_bcd8(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 10);
    units = 4'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/wash_timer_if.sv
// rtl/wash_timer_if.sv - control/status bundle between the wash timer and its host
// Purpose: groups the start/pause controls and the seconds/phase/busy/done status.
// Ports:   master drives start, pause and observes status; slave is the timer.
interface wash_timer_if;
  logic       start;
  logic       pause;
  logic [7:0] seconds;
  logic [1:0] phase;
  logic       busy;
  logic       done;

  modport master (output start, pause, input seconds, phase, busy, done);
  modport slave  (input start, pause, output seconds, phase, busy, done);
endinterface

// File: rtl/wash_tick_gen.sv
// rtl/wash_tick_gen.sv - one-second prescaler for the wash timer
// Purpose: counts 0..TICK_DIV-1 while en is high and pulses tick on the last
//          count, then wraps; holds its value while en is low.
// Ports:   CP clock, RST sync active-high reset, clr sync clear, en count
//          enable, tick one-cycle output.
module wash_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CP,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Gated by en so a tick due while paused is held off rather than dropped.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge CP) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wash_timer.sv
// rtl/wash_timer.sv - wash-cycle countdown sequencer (WASH, RINSE, optional SPIN)
// Purpose: counts down each phase in packed BCD seconds, steps phases, and
//          pulses done at the end of the cycle. Macro WASH_SPIN_EN adds the
//          SPIN phase after RINSE; without it the cycle ends after RINSE.
// Ports:   CP clock, RST sync active-high reset, bus (slave): start, pause in;
//          seconds, phase, busy, done out.
module wash_timer
  import wash_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned WASH_SEC  = 30,
  parameter int unsigned RINSE_SEC = 20,
  parameter int unsigned SPIN_SEC  = 10
) (
  input logic         CP,
  input logic         RST,
  wash_timer_if.slave bus
);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("wash_timer: TICK_DIV must be at least 2");
  end
  if (WASH_SEC < 1 || WASH_SEC > 99) begin : g_bad_wash
    $error("wash_timer: WASH_SEC out of range 1..99");
  end
  if (RINSE_SEC < 1 || RINSE_SEC > 99) begin : g_bad_rinse
    $error("wash_timer: RINSE_SEC out of range 1..99");
  end
  if (SPIN_SEC < 1 || SPIN_SEC > 99) begin : g_bad_spin
    $error("wash_timer: SPIN_SEC out of range 1..99");
  end

  localparam logic [7:0] WASH_BCD  = to_bcd8(WASH_SEC);
  localparam logic [7:0] RINSE_BCD = to_bcd8(RINSE_SEC);
`ifdef WASH_SPIN_EN
  localparam logic [7:0] SPIN_BCD  = to_bcd8(SPIN_SEC);
`endif

  phase_t     state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic       done_q, done_d;
  logic       clr;
  logic       tick;
  logic       busy;

  // Only called with sec > 01, so the tens digit never underflows.
  function automatic logic [7:0] bcd_dec(input logic [7:0] s);
    if (s[3:0] == 4'd0) return {s[7:4] - 4'd1, 4'd9};
    else                return {s[7:4], s[3:0] - 4'd1};
  endfunction

  assign busy = (state_q != PH_IDLE);

  wash_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CP   (CP),
    .RST  (RST),
    .clr  (clr),
    .en   (busy && !bus.pause),
    .tick (tick)
  );

  always_ff @(posedge CP) begin
    if (RST) begin
      state_q <= PH_IDLE;
      sec_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    if (state_q == PH_IDLE) begin
      if (bus.start) begin
        state_d = PH_WASH;
        sec_d   = WASH_BCD;
        clr     = 1'b1;
      end
    end else if (tick) begin
      if (sec_q != 8'h01) begin
        sec_d = bcd_dec(sec_q);
      end else begin
        case (state_q)
          PH_WASH: begin
            state_d = PH_RINSE;
            sec_d   = RINSE_BCD;
          end
`ifdef WASH_SPIN_EN
          PH_RINSE: begin
            state_d = PH_SPIN;
            sec_d   = SPIN_BCD;
          end
`endif
          default: begin
            state_d = PH_IDLE;
            sec_d   = 8'h00;
            done_d  = 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.seconds = sec_q;
  assign bus.phase   = state_q;
  assign bus.busy    = busy;
  assign bus.done    = done_q;

endmodule
